// File: rtl/axi_addr_burst_splitter_if.sv
// AXI read/write address channel plus a per-burst completion pulse.
// The splitter sits on the master side; a slave or bench sits on the other side.
`timescale 1ns/1ps
interface axi_addr_burst_splitter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 4
) ();
    logic [ID_W-1:0]   AxID;
    logic [ADDR_W-1:0] AxADDR;
    logic [7:0]        AxLEN;
    logic [2:0]        AxSIZE;
    logic [1:0]        AxBURST;
    logic              AxLOCK;
    logic [3:0]        AxCACHE;
    logic [2:0]        AxPROT;
    logic [3:0]        AxQOS;
    logic [3:0]        AxREGION;
    logic              AxVALID;
    logic              AxREADY;
    // One-cycle pulse per finished burst (B response or last R beat).
    logic              resp_done;

    modport master (
        output AxID, AxADDR, AxLEN, AxSIZE, AxBURST, AxLOCK, AxCACHE,
               AxPROT, AxQOS, AxREGION, AxVALID,
        input  AxREADY, resp_done
    );

    modport slave (
        input  AxID, AxADDR, AxLEN, AxSIZE, AxBURST, AxLOCK, AxCACHE,
               AxPROT, AxQOS, AxREGION, AxVALID,
        output AxREADY, resp_done
    );
endinterface

// File: rtl/axi_addr_burst_splitter.sv
// Splits one transfer command into legal AXI bursts (MAX_LEN cap, no INCR 4 KB
// crossing), issues them on AR/AW, limits outstanding bursts, reports done/error.
`timescale 1ns/1ps
module axi_addr_burst_splitter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned ID_VALUE   = 0,
    parameter int unsigned MAX_LEN    = 256,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned BEATS_W    = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [BEATS_W-1:0] total_beats,
    input  logic [2:0]         size_log2,
    input  logic [1:0]         burst_type,
    output logic               done,
    output logic               error,
    output logic [3:0]         outstanding,
    output logic [BEATS_W-1:0] bursts_issued,
    output logic [2:0]         current_state_out,
    axi_addr_burst_splitter_if.master ax
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_CALC      = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_COMPLETE  = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int unsigned SIZE_MAX = $clog2(DATA_BYTES);
    // Length arithmetic must hold both the remaining count and the 4096-byte page room.
    localparam int unsigned CW = (BEATS_W > 13) ? BEATS_W : 13;
    localparam logic [CW-1:0] MAX_LEN_C   = CW'(MAX_LEN);
    localparam logic [CW-1:0] FIXED_MAX   = CW'(16);
    localparam logic [3:0]    OUTST_LIMIT = 4'(MAX_OUTST);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [BEATS_W-1:0]  remaining_q;
    logic [BEATS_W-1:0]  total_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [8:0]          len_q;
    logic [3:0]          out_next;

    logic                cmd_err;
    logic                wrap_len_ok;
    logic [ADDR_W-1:0]   align_mask;
    logic [12:0]         page_room;
    logic [CW-1:0]       bnd_beats;
    logic [CW-1:0]       len_sel;
    logic [8:0]          len_calc;
    logic                hs;

    assign hs = (state == ST_ISSUE) && ax.AxREADY;

    // NOTE: every always_comb output gets a default on entry so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        align_mask  = ~({ADDR_W{1'b1}} << size_log2);
        wrap_len_ok = (total_beats == BEATS_W'(2)) || (total_beats == BEATS_W'(4)) ||
                      (total_beats == BEATS_W'(8)) || (total_beats == BEATS_W'(16));
        cmd_err     = (total_beats == '0) ||
                      (32'(size_log2) > SIZE_MAX) ||
                      (burst_type == 2'b11) ||
                      ((start_addr & align_mask) != '0) ||
                      ((burst_type == BURST_WRAP) && !wrap_len_ok);
    end

    always_comb begin
        page_room = 13'h1000 - {1'b0, addr_q[11:0]};
        bnd_beats = CW'(page_room >> size_q);
        len_sel   = CW'(remaining_q);
        case (burst_q)
            BURST_INCR: begin
                if (MAX_LEN_C < len_sel) len_sel = MAX_LEN_C;
                if (bnd_beats < len_sel) len_sel = bnd_beats;
            end
            BURST_FIXED: if (FIXED_MAX < len_sel) len_sel = FIXED_MAX;
            default:     len_sel = CW'(total_q);
        endcase
        len_calc = len_sel[8:0];
    end

    // A completion arriving with a new acceptance cancels out; stray completions saturate.
    always_comb begin
        out_next = outstanding;
        if (hs && !ax.resp_done)
            out_next = outstanding + 4'd1;
        else if (!hs && ax.resp_done && (outstanding != 4'd0))
            out_next = outstanding - 4'd1;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET:     state_next = ST_IDLE;
            ST_IDLE:      if (go) state_next = cmd_err ? ST_ERROR : ST_CALC;
            ST_CALC:      if ((outstanding != OUTST_LIMIT) || ax.resp_done) state_next = ST_ISSUE;
            ST_ISSUE:     if (hs) state_next = (remaining_q == BEATS_W'(len_q)) ? ST_WAIT_RESP : ST_CALC;
            ST_WAIT_RESP: if (out_next == 4'd0) state_next = ST_COMPLETE;
            ST_COMPLETE,
            ST_ERROR:     if (!go) state_next = ST_IDLE;
            default:      state_next = ST_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_RESET;
            outstanding   <= '0;
            bursts_issued <= '0;
            addr_q        <= '0;
            remaining_q   <= '0;
            total_q       <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            len_q         <= '0;
        end else begin
            state       <= state_next;
            outstanding <= out_next;
            case (state)
                ST_IDLE: if (go) begin
                    addr_q      <= start_addr;
                    remaining_q <= total_beats;
                    total_q     <= total_beats;
                    size_q      <= size_log2;
                    burst_q     <= burst_type;
                end
                ST_CALC: len_q <= len_calc;
                ST_ISSUE: if (hs) begin
                    remaining_q <= remaining_q - BEATS_W'(len_q);
                    if (burst_q == BURST_INCR)
                        addr_q <= addr_q + (ADDR_W'(len_q) << size_q);
                end
                default: ;
            endcase
            if (hs)
                bursts_issued <= bursts_issued + 1'b1;
            else if (state_next == ST_IDLE)
                bursts_issued <= '0;
        end
    end

    // Burst fields are only meaningful while a burst is being prepared or offered.
    always_comb begin
        ax.AxADDR  = '0;
        ax.AxLEN   = '0;
        ax.AxSIZE  = '0;
        ax.AxBURST = '0;
        if (state == ST_CALC || state == ST_ISSUE) begin
            ax.AxADDR  = addr_q;
            ax.AxLEN   = (state == ST_ISSUE) ? 8'(len_q - 9'd1) : 8'(len_calc - 9'd1);
            ax.AxSIZE  = size_q;
            ax.AxBURST = burst_q;
        end
    end

    assign ax.AxVALID  = (state == ST_ISSUE);
    assign ax.AxID     = ID_W'(ID_VALUE);
    assign ax.AxLOCK   = 1'b0;
    assign ax.AxCACHE  = 4'd0;
    assign ax.AxPROT   = 3'd0;
    assign ax.AxQOS    = 4'd0;
    assign ax.AxREGION = 4'd0;

    assign done              = (state == ST_COMPLETE) || (state == ST_ERROR);
    assign error             = (state == ST_ERROR);
    assign current_state_out = state;

endmodule

// File: tb/tb_axi_addr_burst_splitter.sv
// Directed bench for axi_addr_burst_splitter: two instances (default limits and
// a tight MAX_OUTST=2/MAX_LEN=16 one) checked against a burst scoreboard.
`timescale 1ns/1ps
module tb_axi_addr_burst_splitter;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } burst_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        go_a, go_b;
    logic [31:0] start_addr;
    logic [15:0] total_beats;
    logic [2:0]  size_log2;
    logic [1:0]  burst_type;

    logic        done_a, error_a, done_b, error_b;
    logic [3:0]  outst_a, outst_b;
    logic [15:0] bursts_a, bursts_b;
    logic [2:0]  state_a, state_b;

    int checks   = 0;
    int failures = 0;
    int hs_cnt_a = 0, hs_cnt_b = 0, rsp_cnt_a = 0, valid_cycles_a = 0;
    bit auto_resp_a = 1'b1;
    burst_t exp_a[$];
    burst_t exp_b[$];

    axi_addr_burst_splitter_if #(.ADDR_W(32), .ID_W(4)) ifa ();
    axi_addr_burst_splitter_if #(.ADDR_W(32), .ID_W(4)) ifb ();

    axi_addr_burst_splitter #(
        .ADDR_W(32), .ID_W(4), .ID_VALUE(5), .MAX_LEN(256),
        .MAX_OUTST(4), .DATA_BYTES(8), .BEATS_W(16)
    ) dut_a (
        .clk(clk), .resetn(resetn), .go(go_a), .start_addr(start_addr),
        .total_beats(total_beats), .size_log2(size_log2), .burst_type(burst_type),
        .done(done_a), .error(error_a), .outstanding(outst_a),
        .bursts_issued(bursts_a), .current_state_out(state_a), .ax(ifa)
    );

    axi_addr_burst_splitter #(
        .ADDR_W(32), .ID_W(4), .ID_VALUE(0), .MAX_LEN(16),
        .MAX_OUTST(2), .DATA_BYTES(8), .BEATS_W(16)
    ) dut_b (
        .clk(clk), .resetn(resetn), .go(go_b), .start_addr(start_addr),
        .total_beats(total_beats), .size_log2(size_log2), .burst_type(burst_type),
        .done(done_b), .error(error_b), .outstanding(outst_b),
        .bursts_issued(bursts_b), .current_state_out(state_b), .ax(ifb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit to_b, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b);
        burst_t e;
        e = '{addr: a, len: l, size: s, burst: b};
        if (to_b) exp_b.push_back(e);
        else      exp_a.push_back(e);
    endtask

    task automatic wait_state(input bit use_b, input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((use_b ? state_b : state_a) == s) break;
        end
        check(tag, use_b ? state_b : state_a, s);
    endtask

    task automatic start_cmd(input bit to_b, input logic [31:0] a, input logic [15:0] beats,
                             input logic [2:0] s, input logic [1:0] b);
        start_addr  = a;
        total_beats = beats;
        size_log2   = s;
        burst_type  = b;
        if (to_b) go_b = 1'b1;
        else      go_a = 1'b1;
    endtask

    task automatic end_cmd(input bit to_b, input string tag);
        tick();
        if (to_b) go_b = 1'b0;
        else      go_a = 1'b0;
        wait_state(to_b, 3'd1, 10, tag);
    endtask

    // Scoreboard: every accepted burst must match the next expected one.
    always @(negedge clk) begin
        burst_t e;
        if (ifa.AxVALID) valid_cycles_a++;
        if (ifa.AxVALID && ifa.AxREADY) begin
            hs_cnt_a++;
            if (exp_a.size() == 0) check("a_unexpected_burst", ifa.AxADDR, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                e = exp_a.pop_front();
                check("a_addr",  ifa.AxADDR,  e.addr);
                check("a_len",   ifa.AxLEN,   e.len);
                check("a_size",  ifa.AxSIZE,  e.size);
                check("a_burst", ifa.AxBURST, e.burst);
                check("a_id",    ifa.AxID,    4'd5);
            end
        end
        if (ifb.AxVALID && ifb.AxREADY) begin
            hs_cnt_b++;
            if (exp_b.size() == 0) check("b_unexpected_burst", ifb.AxADDR, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                e = exp_b.pop_front();
                check("b_addr",  ifb.AxADDR,  e.addr);
                check("b_len",   ifb.AxLEN,   e.len);
                check("b_size",  ifb.AxSIZE,  e.size);
                check("b_burst", ifb.AxBURST, e.burst);
            end
        end
    end

    // Auto responder for instance A: one resp_done per accepted burst.
    always @(posedge clk) begin
        #1;
        if (auto_resp_a && (hs_cnt_a > rsp_cnt_a)) begin
            ifa.resp_done = 1'b1;
            rsp_cnt_a++;
        end else begin
            ifa.resp_done = 1'b0;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc0;
        resetn = 1'b0; go_a = 1'b0; go_b = 1'b0;
        start_addr = '0; total_beats = '0; size_log2 = '0; burst_type = '0;
        ifa.AxREADY = 1'b1; ifb.AxREADY = 1'b1; ifb.resp_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state",   state_a, 3'd0);
        check("rst_valid",   ifa.AxVALID, 1'b0);
        check("rst_done",    done_a, 1'b0);
        check("rst_error",   error_a, 1'b0);
        check("rst_outst",   outst_a, 4'd0);
        check("rst_bursts",  bursts_a, 16'd0);
        check("rst_addr",    ifa.AxADDR, 32'd0);
        check("rst_len",     ifa.AxLEN, 8'd0);
        check("rst_state_b", state_b, 3'd0);
        check("const_cache", ifa.AxCACHE, 4'd0);
        tick();
        resetn = 1'b1;
        wait_state(1'b0, 3'd1, 3, "rst_to_idle");

        // 1: single INCR burst
        push(1'b0, 32'h1000, 8'd15, 3'd3, 2'b01);
        tick();
        start_cmd(1'b0, 32'h1000, 16'd16, 3'd3, 2'b01);
        wait_state(1'b0, 3'd5, 50, "t1_complete");
        check("t1_done",   done_a, 1'b1);
        check("t1_error",  error_a, 1'b0);
        check("t1_bursts", bursts_a, 16'd1);
        end_cmd(1'b0, "t1_idle");
        check("t1_bursts_clr", bursts_a, 16'd0);

        // 2: 4 KB boundary split
        push(1'b0, 32'h0FC0, 8'd7,  3'd3, 2'b01);
        push(1'b0, 32'h1000, 8'd23, 3'd3, 2'b01);
        tick();
        start_cmd(1'b0, 32'h0FC0, 16'd32, 3'd3, 2'b01);
        wait_state(1'b0, 3'd5, 80, "t2_complete");
        check("t2_bursts", bursts_a, 16'd2);
        check("t2_outst",  outst_a, 4'd0);
        end_cmd(1'b0, "t2_idle");

        // 3: MAX_LEN split
        push(1'b0, 32'h000, 8'd255, 3'd0, 2'b01);
        push(1'b0, 32'h100, 8'd255, 3'd0, 2'b01);
        push(1'b0, 32'h200, 8'd87,  3'd0, 2'b01);
        tick();
        start_cmd(1'b0, 32'h0, 16'd600, 3'd0, 2'b01);
        wait_state(1'b0, 3'd5, 100, "t3_complete");
        check("t3_bursts", bursts_a, 16'd3);
        end_cmd(1'b0, "t3_idle");

        // 5a: backpressure keeps AxVALID and fields stable
        ifa.AxREADY = 1'b0;
        push(1'b0, 32'h2000, 8'd3, 3'd3, 2'b01);
        start_cmd(1'b0, 32'h2000, 16'd4, 3'd3, 2'b01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.AxVALID) break;
        end
        check("bp_valid_up", ifa.AxVALID, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", ifa.AxVALID, 1'b1);
            check("bp_addr",  ifa.AxADDR, 32'h2000);
            check("bp_len",   ifa.AxLEN, 8'd3);
            check("bp_size",  ifa.AxSIZE, 3'd3);
        end
        tick();
        ifa.AxREADY = 1'b1;
        wait_state(1'b0, 3'd5, 30, "bp_complete");
        end_cmd(1'b0, "bp_idle");

        // 5b: rejected commands
        vc0 = valid_cycles_a;
        tick();
        start_cmd(1'b0, 32'h0, 16'd4, 3'd4, 2'b01);
        wait_state(1'b0, 3'd6, 10, "err_size_state");
        check("err_size_done",  done_a, 1'b1);
        check("err_size_error", error_a, 1'b1);
        end_cmd(1'b0, "err_size_idle");
        tick();
        start_cmd(1'b0, 32'h0, 16'd3, 3'd3, 2'b10);
        wait_state(1'b0, 3'd6, 10, "err_wrap_state");
        check("err_wrap_error", error_a, 1'b1);
        end_cmd(1'b0, "err_wrap_idle");
        tick();
        start_cmd(1'b0, 32'h1004, 16'd4, 3'd3, 2'b01);
        wait_state(1'b0, 3'd6, 10, "err_align_state");
        check("err_align_error",  error_a, 1'b1);
        check("err_align_bursts", bursts_a, 16'd0);
        end_cmd(1'b0, "err_align_idle");
        check("err_no_valid", valid_cycles_a, vc0);

        // 4: outstanding throttle on instance B
        push(1'b1, 32'h00, 8'd15, 3'd0, 2'b01);
        push(1'b1, 32'h10, 8'd15, 3'd0, 2'b01);
        push(1'b1, 32'h20, 8'd15, 3'd0, 2'b01);
        push(1'b1, 32'h30, 8'd15, 3'd0, 2'b01);
        tick();
        start_cmd(1'b1, 32'h0, 16'd64, 3'd0, 2'b01);
        repeat (20) @(negedge clk);
        check("thr_hs2",    hs_cnt_b, 2);
        check("thr_valid",  ifb.AxVALID, 1'b0);
        check("thr_outst",  outst_b, 4'd2);
        check("thr_state",  state_b, 3'd2);
        tick();
        ifb.resp_done = 1'b1;
        tick();
        ifb.resp_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (hs_cnt_b == 3) break;
        end
        check("thr_hs3", hs_cnt_b, 3);
        for (int k = 0; k < 5; k++) begin
            tick();
            ifb.resp_done = 1'b1;
            tick();
            ifb.resp_done = 1'b0;
            tick();
        end
        wait_state(1'b1, 3'd5, 30, "thr_complete");
        check("thr_bursts", bursts_b, 16'd4);
        check("thr_outst0", outst_b, 4'd0);
        tick();
        ifb.resp_done = 1'b1;
        tick();
        ifb.resp_done = 1'b0;
        @(negedge clk);
        check("thr_saturate", outst_b, 4'd0);
        end_cmd(1'b1, "thr_idle");

        // 6: reset while a burst is offered with one outstanding
        auto_resp_a = 1'b0;
        push(1'b0, 32'h0FC0, 8'd7, 3'd3, 2'b01);
        vc0 = hs_cnt_a;
        tick();
        start_cmd(1'b0, 32'h0FC0, 16'd32, 3'd3, 2'b01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hs_cnt_a == vc0 + 1) break;
        end
        check("rsti_first_hs", hs_cnt_a, vc0 + 1);
        tick();
        ifa.AxREADY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifa.AxVALID) break;
        end
        check("rsti_valid", ifa.AxVALID, 1'b1);
        check("rsti_outst", outst_a, 4'd1);
        tick();
        resetn = 1'b0;
        go_a   = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("rsti_state0", state_a, 3'd0);
        check("rsti_valid0", ifa.AxVALID, 1'b0);
        check("rsti_outst0", outst_a, 4'd0);
        check("rsti_addr0",  ifa.AxADDR, 32'd0);
        @(negedge clk);
        check("rsti_state1", state_a, 3'd1);

        check("sb_a_empty", exp_a.size(), 0);
        check("sb_b_empty", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_addr_burst_splitter.md
Name: axi_addr_burst_splitter

Overview:
Parametrised AXI address-channel master, next generation of the single-burst address controller. Accepts one transfer command (start address, total beat count, beat size, burst type). Splits it into legal AXI bursts: max length MAX_LEN, no INCR burst crosses a 4 KB boundary. Issues the bursts on the AR/AW channel, throttles on an outstanding-burst limit, and reports done once every burst response has returned. Usable for both read and write address channels.

Parameters:
ADDR_W, 32, address width (min 13)
ID_W, 4, AxID width
ID_VALUE, 0, constant driven on AxID
MAX_LEN, 256, max beats per INCR burst (1..256)
MAX_OUTST, 4, max accepted bursts awaiting resp_done (1..15)
DATA_BYTES, 8, data bus width in bytes (power of 2, 1..128)
BEATS_W, 16, width of total_beats and bursts_issued

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
go  in  1  command request, level; held high until done seen
start_addr  in  ADDR_W  transfer start byte address, sampled in IDLE when go=1
total_beats  in  BEATS_W  total beats, sampled with start_addr
size_log2  in  3  beat size = 2^size_log2 bytes
burst_type  in  2  00 FIXED, 01 INCR, 10 WRAP
done  out  1  transfer finished (ok or error), held until go=0
error  out  1  command rejected, valid while done=1
AxID  out  ID_W  = ID_VALUE
AxADDR  out  ADDR_W  burst address
AxLEN  out  8  beats-1
AxSIZE  out  3  = size_log2 while issuing
AxBURST  out  2  = burst_type while issuing
AxLOCK, AxCACHE, AxPROT, AxQOS, AxREGION  out  1/4/3/4/4  constant 0
AxVALID  out  1  address valid
AxREADY  in  1  slave ready
resp_done  in  1  one-cycle pulse per completed burst (B or last R)
outstanding  out  4  bursts accepted and not yet responded
bursts_issued  out  BEATS_W  bursts accepted in current command
current_state_out  out  3  state encoding, see below

Behaviour:
- Reset: state RESET. AxVALID, done, error = 0. outstanding and bursts_issued = 0. AxADDR, AxLEN, AxSIZE, AxBURST = 0. Reset has priority in any state, including mid-handshake; in-flight bursts are abandoned.
- States and current_state_out encoding: RESET 000, IDLE 001, CALC 010, ISSUE 011, WAIT_RESP 100, COMPLETE 101, ERROR 110.
- RESET -> IDLE unconditionally after one cycle.
- IDLE + go=1: register the command, then validate it. The command is an error if any of the following holds:
  - total_beats=0
  - 2^size_log2 > DATA_BYTES
  - burst_type=11
  - start_addr not aligned to 2^size_log2
  - WRAP with total_beats not in {2,4,8,16}
  Error -> ERROR; otherwise -> CALC.
- CALC (1 cycle minimum): compute the next burst length L.
  - INCR: L = min(remaining, MAX_LEN, (4096 - addr[11:0]) >> size_log2).
  - FIXED: L = min(remaining, 16).
  - WRAP: L = total_beats (single burst).
  - Register AxADDR=addr, AxLEN=L-1. If outstanding = MAX_OUTST, stay in CALC with AxVALID=0; else -> ISSUE.
- ISSUE: AxVALID=1. All Ax* fields stay stable until AxREADY=1; AxVALID never drops before the handshake.
- On handshake:
  - bursts_issued+1, outstanding+1, remaining -= L.
  - Next address: INCR addr += L << size_log2; FIXED and WRAP keep addr.
  - remaining > 0 -> CALC; else -> WAIT_RESP.
  - AxVALID=0 in the cycle after the handshake.
- outstanding:
  - Decrements on resp_done.
  - Handshake and resp_done in the same cycle: net unchanged.
  - resp_done while outstanding=0: ignored (saturate at 0).
- WAIT_RESP: -> COMPLETE when outstanding = 0, including the cycle its last decrement takes effect.
- COMPLETE: done=1, error=0. go=0 -> IDLE; bursts_issued clears on entry to IDLE.
- ERROR: done=1, error=1, no bursts issued. go=0 -> IDLE.
- Outside ISSUE and CALC, AxADDR, AxLEN, AxSIZE and AxBURST drive 0.
- All arithmetic is unsigned. Address increment wraps modulo 2^ADDR_W; the 4 KB rule means it never wraps inside a burst.

Test Plan:
1. INCR, addr 0x1000, beats 16, size 3, AxREADY tied high -> one burst: AxADDR 0x1000, AxLEN 15, AxSIZE 3, AxBURST 01. One resp_done -> done=1, error=0; go=0 -> state 001.
2. 4 KB split: addr 0x0FC0, beats 32, size 3 -> bursts (0x0FC0, AxLEN 7) then (0x1000, AxLEN 23); bursts_issued=2; done after 2 resp_done.
3. MAX_LEN split: addr 0x0, beats 600, size 0 -> bursts (0x000, AxLEN 255), (0x100, AxLEN 255), (0x200, AxLEN 87).
4. Throttle: MAX_OUTST=2, addr 0, beats 64, size 0, MAX_LEN 16, no resp_done -> exactly 2 handshakes, then AxVALID=0 with outstanding=2. One resp_done pulse -> third burst issued within 2 cycles.
5. Backpressure plus errors:
   - AxREADY low 5 cycles -> AxVALID and fields stable throughout.
   - size_log2=4 with DATA_BYTES=8 -> state 110, done=1, error=1, AxVALID never asserted.
   - WRAP beats 3 -> error.
   - Unaligned addr 0x1004 with size 3 -> error.
6. Reset mid-ISSUE (AxVALID=1, outstanding=1) -> next cycle AxVALID=0, outstanding=0, state 000, then 001.
